cla_addsub_pipe: RTL and testbench

Two-stage pipelined carry-lookahead adder/subtractor that consumes per-bit generate/propagate terms (G = A·B, P = A⊕B) and resolves them into carries, sum and status flags. It sits at the consumer end of the adder datapath: stage 1 forms bit and 4-bit group G/P, and stage 2 performs block lookahead, sum and flag generation. Operands arrive and results leave over valid/ready handshakes with full backpressure. Throughput is one operation per cycle.

---
 rtl/cla_addsub_pipe_if.sv | 34 +++
 rtl/cla_addsub_pipe.sv | 157 +++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cla_addsub_pipe_if.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe_if
// Handshake bundle for the pipelined carry-lookahead adder/subtractor.
//   Operand side : in_valid, in_ready, a, b, sub
//   Result side  : out_valid, out_ready, sum, cout, ovf, zero
// Modports:
//   slave  - the adder itself (consumes operands, produces results)
//   master - the environment driving operands and accepting results
// -----------------------------------------------------------------------------
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
// Two-stage pipelined carry-lookahead adder/subtractor.
//   Stage 1 forms per-bit generate/propagate and 4-bit group GG/GP.
//   Stage 2 resolves block carries, in-group carries, sum and flags.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   io   - cla_addsub_pipe_if.slave
//          in_valid/in_ready/a/b/sub    operand beat (sub=1 computes a-b)
//          out_valid/out_ready          result handshake
//          sum  result modulo 2^WIDTH
//          cout carry out of MSB (subtract: 1 = no borrow)
//          ovf  signed overflow
//          zero sum == 0
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  cla_addsub_pipe_if.slave  io
);

  localparam int NG = WIDTH / 4;

  // Group generate/propagate of one 4-bit slice, returned as {GG, GP}.
  function automatic logic [1:0] f_group_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    logic gp;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp = &p;
    return {gg, gp};
  endfunction

  // Full carry vector: c[i] is the carry into bit i, c[WIDTH] the carry out.
  // Block carries chain through GG/GP; inside a group every carry is a
  // lookahead term from that group's carry-in, never a ripple.
  function automatic logic [WIDTH:0] f_carries(
    input logic [WIDTH-1:0] g,
    input logic [WIDTH-1:0] p,
    input logic [NG-1:0]    gg,
    input logic [NG-1:0]    gp,
    input logic             cin
  );
    logic [WIDTH:0] c;
    logic           bc;
    c  = '0;
    bc = cin;
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = bc;
      c[4*k+1] = g[4*k] | (p[4*k] & bc);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & bc);
      bc       = gg[k] | (gp[k] & bc);
    end
    c[WIDTH] = bc;
    return c;
  endfunction

  logic [WIDTH-1:0] w_bx_p0;
  logic [WIDTH-1:0] w_g_p0;
  logic [WIDTH-1:0] w_p_p0;
  logic [NG-1:0]    w_gg_p0;
  logic [NG-1:0]    w_gp_p0;
  logic             w_in_xfer;

  logic [WIDTH-1:0] r_g_p1;
  logic [WIDTH-1:0] r_p_p1;
  logic [NG-1:0]    r_gg_p1;
  logic [NG-1:0]    r_gp_p1;
  logic             r_cin_p1;
  logic             r_vld_p1;

  logic [WIDTH:0]   w_c_p1;
  logic [WIDTH-1:0] w_sum_p1;
  logic             w_s2_load;

  logic [WIDTH-1:0] r_sum_p2;
  logic             r_cout_p2;
  logic             r_ovf_p2;
  logic             r_zero_p2;
  logic             r_vld_p2;

  // ---- Stage 0 -> 1: operand prep, bit and group G/P ----
  assign w_bx_p0 = io.sub ? ~io.b : io.b;
  assign w_g_p0  = io.a & w_bx_p0;
  assign w_p_p0  = io.a ^ w_bx_p0;

  always_comb begin
    w_gg_p0 = '0;
    w_gp_p0 = '0;
    for (int k = 0; k < NG; k++) begin
      {w_gg_p0[k], w_gp_p0[k]} = f_group_gp(w_g_p0[4*k +: 4], w_p_p0[4*k +: 4]);
    end
  end

  // Stage 2 can take a new result when it is empty or being drained now.
  assign w_s2_load   = r_vld_p1 && (!r_vld_p2 || io.out_ready);
  assign io.in_ready = !r_vld_p1 || w_s2_load;
  assign w_in_xfer   = io.in_valid && io.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g_p1   <= '0;
      r_p_p1   <= '0;
      r_gg_p1  <= '0;
      r_gp_p1  <= '0;
      r_cin_p1 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_g_p1   <= w_g_p0;
        r_p_p1   <= w_p_p0;
        r_gg_p1  <= w_gg_p0;
        r_gp_p1  <= w_gp_p0;
        r_cin_p1 <= io.sub;
        r_vld_p1 <= 1'b1;
      end else if (w_s2_load) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  // ---- Stage 1 -> 2: carry lookahead, sum and flags ----
  assign w_c_p1   = f_carries(r_g_p1, r_p_p1, r_gg_p1, r_gp_p1, r_cin_p1);
  assign w_sum_p1 = r_p_p1 ^ w_c_p1[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_p2  <= '0;
      r_cout_p2 <= 1'b0;
      r_ovf_p2  <= 1'b0;
      r_zero_p2 <= 1'b0;
      r_vld_p2  <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_sum_p2  <= w_sum_p1;
        r_cout_p2 <= w_c_p1[WIDTH];
        r_ovf_p2  <= w_c_p1[WIDTH] ^ w_c_p1[WIDTH-1];
        r_zero_p2 <= (w_sum_p1 == '0);
        r_vld_p2  <= 1'b1;
      end else if (io.out_ready) begin
        r_vld_p2  <= 1'b0;
      end
    end
  end

  // ---- Stage 2 -> output ----
  assign io.out_valid = r_vld_p2;
  assign io.sum       = r_sum_p2;
  assign io.cout      = r_cout_p2;
  assign io.ovf       = r_ovf_p2;
  assign io.zero      = r_zero_p2;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_addsub_pipe
// Directed, table-driven bench for cla_addsub_pipe (WIDTH = 16).
// -----------------------------------------------------------------------------
module tb_cla_addsub_pipe;

  localparam int W = 16;

  logic clk;
  logic rst;

  cla_addsub_pipe_if #(.WIDTH(W)) bus ();

  cla_addsub_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
    logic         e_zero;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  int n_vec;
  int n_bad;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input logic [W-1:0] s, input logic c,
                         input logic o, input logic z);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.sum !== s || bus.cout !== c ||
        bus.ovf !== o || bus.zero !== z) begin
      n_bad++;
      $display("FAIL %s: got v=%b sum=%h c=%b o=%b z=%b, expected v=1 sum=%h c=%b o=%b z=%b",
               nm, bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, s, c, o, z);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;

    //            a        b        sub   sum      cout  ovf   zero
    vt[0]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vt[3]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vt[10] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[11] = '{16'hABCD, 16'h5433, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[12] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[13] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0};
    vt[14] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    vt[15] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    chk_bit("rst_out_valid", bus.out_valid, 1'b0);
    chk_bit("rst_cout", bus.cout, 1'b0);
    chk_bit("rst_ovf", bus.ovf, 1'b0);
    chk_bit("rst_zero", bus.zero, 1'b0);
    chk_bit("rst_sum_zero", (bus.sum == '0), 1'b1);
    chk_bit("rst_in_ready", bus.in_ready, 1'b1);

    // Streaming: all vectors back to back, one result per cycle in order
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vt[i].a, vt[i].b, vt[i].sub);
      chk_bit($sformatf("stream_in_ready_%0d", i), bus.in_ready, 1'b1);
      step();
      if (i == 0) chk_bit("stream_latency_empty", bus.out_valid, 1'b0);
      else chk_res($sformatf("stream_vec_%0d", i - 1), vt[i-1].e_sum, vt[i-1].e_cout,
                   vt[i-1].e_ovf, vt[i-1].e_zero);
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk_res($sformatf("stream_vec_%0d", NV - 1), vt[NV-1].e_sum, vt[NV-1].e_cout,
            vt[NV-1].e_ovf, vt[NV-1].e_zero);
    step();
    chk_bit("stream_drained", bus.out_valid, 1'b0);

    // Backpressure: X and Y fill the pipe, Z waits
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0003, 16'h0004, 1'b0);
    chk_bit("bp_accept_x", bus.in_ready, 1'b1);
    step();
    drive(1'b1, 16'h0010, 16'h0001, 1'b1);
    chk_bit("bp_accept_y", bus.in_ready, 1'b1);
    step();
    drive(1'b1, 16'h0001, 16'h0001, 1'b0);
    chk_bit("bp_block_z", bus.in_ready, 1'b0);
    for (int s = 0; s < 4; s++) begin
      step();
      chk_res($sformatf("bp_hold_x_%0d", s), 16'h0007, 1'b0, 1'b0, 1'b0);
      chk_bit($sformatf("bp_stall_ready_%0d", s), bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk_bit("bp_release_ready", bus.in_ready, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    chk_res("bp_out_y", 16'h000F, 1'b1, 1'b0, 1'b0);
    step();
    chk_res("bp_out_z", 16'h0002, 1'b0, 1'b0, 1'b0);
    step();
    chk_bit("bp_drained", bus.out_valid, 1'b0);

    // Reset mid-operation: two ops in flight, output stalled, then rst
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1111, 16'h2222, 1'b0);
    step();
    drive(1'b1, 16'h0100, 16'h0001, 1'b1);
    step();
    chk_res("mid_first_ready", 16'h3333, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 16'h4444, 16'h1111, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    chk_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk_bit("mid_rst_sum_zero", (bus.sum == '0), 1'b1);
    chk_bit("mid_rst_cout", bus.cout, 1'b0);
    chk_bit("mid_rst_zero", bus.zero, 1'b0);
    chk_bit("mid_rst_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk_bit($sformatf("mid_no_stale_%0d", s), bus.out_valid, 1'b0);
    end

    // Pipe still works after the mid-operation reset
    drive(1'b1, vt[5].a, vt[5].b, vt[5].sub);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk_res("post_rst_vec", vt[5].e_sum, vt[5].e_cout, vt[5].e_ovf, vt[5].e_zero);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
